// File: rtl/ofdm_cp_adder_if.sv
// Avalon-ST style streaming bundle: data word with sop/eop framing and valid/ready handshake.
// The source drives through master; the sink receives through slave.
interface ofdm_cp_adder_if #(
  parameter int unsigned Width = 28
) ();
  logic [Width-1:0] data;
  logic             valid;
  logic             sop;
  logic             eop;
  logic             ready;

  modport master (output data, valid, sop, eop, input ready);
  modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/ofdm_cp_adder.sv
// Cyclic-prefix inserter: ping-pong buffers NFFT-sample symbols and replays the last CP_LEN
// samples ahead of each full symbol on a registered Avalon-ST source.
module ofdm_cp_adder #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned NFFT   = 64,
  parameter int unsigned CP_LEN = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  ofdm_cp_adder_if.slave         asi,
  ofdm_cp_adder_if.master        aso,
  output logic                   err_frame,
  output logic [15:0]            sym_count
);
  localparam int unsigned IdxW = $clog2(NFFT);
  localparam int unsigned SmpW = 2 * DATA_W;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NFFT - 1);
  localparam logic [IdxW-1:0] CpStart = IdxW'(NFFT - CP_LEN);

  typedef enum logic {WrHunt, WrFill} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdCp, RdBody} rd_state_e;

  logic [SmpW-1:0] mem_q [2*NFFT];
  logic [1:0]      full_q, full_d;

  // Writer
  wr_state_e       wr_state_q, wr_state_d;
  logic            wb_q, wb_d;
  logic [IdxW-1:0] wi_q, wi_d;
  logic [IdxW-1:0] wr_idx;
  logic            sink_xfer, wr_en, set_full, err_d;

  // Reader and output register
  rd_state_e       rd_state_q, rd_state_d;
  logic            rb_q, rb_d;
  logic [IdxW-1:0] ri_q, ri_d;
  logic            fetch, fetch_sop, fetch_eop, other_full, src_xfer, clr_full;
  logic [SmpW-1:0] out_data_q;
  logic            out_valid_q, out_sop_q, out_eop_q, out_bank_q;

  // ---------------- writer ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= WrHunt;
      wb_q       <= 1'b0;
      wi_q       <= '0;
      err_frame  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wb_q       <= wb_d;
      wi_q       <= wi_d;
      err_frame  <= err_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wb_d       = wb_q;
    wi_d       = wi_q;
    wr_en      = 1'b0;
    wr_idx     = wi_q;
    set_full   = 1'b0;
    err_d      = 1'b0;
    unique case (wr_state_q)
      WrHunt: begin
        if (sink_xfer && asi.sop) begin
          wr_en      = 1'b1;
          wr_idx     = '0;
          wi_d       = IdxW'(1);
          wr_state_d = WrFill;
        end
      end
      WrFill: begin
        if (sink_xfer) begin
          wr_en = 1'b1;
          if (asi.sop) begin
            // Early sop restarts the same bank; the partial symbol is lost.
            err_d  = 1'b1;
            wr_idx = '0;
            wi_d   = IdxW'(1);
          end else if (wi_q == LastIdx) begin
            set_full   = 1'b1;
            wb_d       = ~wb_q;
            wi_d       = '0;
            wr_state_d = WrHunt;
          end else begin
            wi_d = wi_q + 1'b1;
          end
        end
      end
      default: wr_state_d = WrHunt;
    endcase
  end

  always_comb begin
    asi.ready = !reset && !full_q[wb_q];
    sink_xfer = asi.valid && asi.ready;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wb_q, wr_idx}] <= asi.data;
    end
  end

  // ---------------- bank flags ----------------
  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wb_q] = 1'b1;
    if (clr_full) full_d[out_bank_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 2'b00;
    end else begin
      full_q <= full_d;
    end
  end

  // ---------------- reader ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q <= RdIdle;
      rb_q       <= 1'b0;
      ri_q       <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rb_q       <= rb_d;
      ri_q       <= ri_d;
    end
  end

  // Look through a same-cycle fill so back-to-back symbols chain without a bubble.
  assign other_full = full_q[~rb_q] || (set_full && (wb_q == ~rb_q));

  always_comb begin
    rd_state_d = rd_state_q;
    rb_d       = rb_q;
    ri_d       = ri_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (full_q[rb_q]) begin
          rd_state_d = RdCp;
          ri_d       = CpStart;
        end
      end
      RdCp: begin
        if (fetch) begin
          if (ri_q == LastIdx) begin
            rd_state_d = RdBody;
            ri_d       = '0;
          end else begin
            ri_d = ri_q + 1'b1;
          end
        end
      end
      RdBody: begin
        if (fetch) begin
          if (ri_q == LastIdx) begin
            rb_d = ~rb_q;
            if (other_full) begin
              rd_state_d = RdCp;
              ri_d       = CpStart;
            end else begin
              rd_state_d = RdIdle;
              ri_d       = '0;
            end
          end else begin
            ri_d = ri_q + 1'b1;
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  always_comb begin
    fetch     = (rd_state_q != RdIdle) && (!out_valid_q || aso.ready);
    fetch_sop = (rd_state_q == RdCp) && (ri_q == CpStart);
    fetch_eop = (rd_state_q == RdBody) && (ri_q == LastIdx);
    src_xfer  = out_valid_q && aso.ready;
    // The bank is released only once its final word has actually left.
    clr_full  = src_xfer && out_eop_q;
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_bank_q  <= 1'b0;
    end else if (fetch) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mem_q[{rb_q, ri_q}];
      out_sop_q   <= fetch_sop;
      out_eop_q   <= fetch_eop;
      out_bank_q  <= rb_q;
    end else if (aso.ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_count <= '0;
    end else if (clr_full) begin
      sym_count <= sym_count + 16'd1;
    end
  end

  always_comb begin
    aso.valid = out_valid_q;
    aso.data  = out_data_q;
    aso.sop   = out_sop_q;
    aso.eop   = out_eop_q;
  end
endmodule

// File: tb/tb_ofdm_cp_adder.sv
// Scoreboard bench for ofdm_cp_adder: directed symbols push expected CP+body words into a queue,
// a monitor pops and compares every accepted output and checks hold-stability under backpressure.
`timescale 1ns/1ps
module tb_ofdm_cp_adder;
  localparam int DW   = 14;
  localparam int NFFT = 64;
  localparam int CP   = 16;
  localparam int W    = 2 * DW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        err_frame;
  logic [15:0] sym_count;

  always #5 clk = ~clk;

  ofdm_cp_adder_if #(.Width(W)) asi ();
  ofdm_cp_adder_if #(.Width(W)) aso ();

  ofdm_cp_adder #(.DATA_W(DW), .NFFT(NFFT), .CP_LEN(CP)) dut (
    .clk       (clk),
    .reset     (reset),
    .asi       (asi),
    .aso       (aso),
    .err_frame (err_frame),
    .sym_count (sym_count)
  );

  logic [W+1:0] exp_q [$];
  int n_cmp = 0, n_err = 0, n_out = 0, acc = 0, bubbles = 0, err_pulses = 0;
  bit contig = 1'b0, rnd_mode = 1'b0;
  logic pv = 1'b0, pr = 1'b0;
  logic [W+1:0] pword, cur, expw;

  function automatic logic [W-1:0] samp(input int i, input int q);
    return {DW'(i), DW'(q)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Expected order: words NFFT-CP..NFFT-1, then 0..NFFT-1.
  task automatic push_exp(input int ib, input int qb);
    for (int j = 0; j < NFFT + CP; j++) begin
      int idx;
      idx = (j < CP) ? (NFFT - CP + j) : (j - CP);
      exp_q.push_back({(j == 0), (j == NFFT + CP - 1), samp(ib + idx, qb + idx)});
    end
  endtask

  task automatic put(input logic [W-1:0] d, input logic s);
    int n;
    n = 0;
    asi.data  = d;
    asi.sop   = s;
    asi.valid = 1'b1;
    while (!asi.ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_cmp++;
      n_err++;
      $display("FAIL put_timeout: got asi_ready=0 for %0d cycles required 1", n);
    end
    @(negedge clk);
    asi.valid = 1'b0;
    asi.sop   = 1'b0;
  endtask

  task automatic send_sym(input int ib, input int qb);
    for (int k = 0; k < NFFT; k++) put(samp(ib + k, qb + k), (k == 0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d words pending required 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Backpressure source: changes just after posedge so it is settled for the monitor.
  always @(posedge clk) begin
    #1;
    if (rnd_mode) aso.ready = 1'($urandom_range(0, 1));
  end

  // Monitor: runs mid-low-phase, after the driver's negedge updates.
  always @(negedge clk) begin
    #3;
    if (reset) begin
      pv = 1'b0;
    end else begin
      cur = {aso.sop, aso.eop, aso.data};
      if (pv && !pr) begin
        n_cmp++;
        if (!aso.valid || cur !== pword) begin
          n_err++;
          $display("FAIL hold: got valid=%0b word=%h required valid=1 word=%h",
                   aso.valid, cur, pword);
        end
      end
      if (asi.valid && asi.ready) acc++;
      if (err_frame) err_pulses++;
      if (contig && aso.ready && !aso.valid && exp_q.size() > 0) bubbles++;
      if (aso.valid && aso.ready) begin
        n_cmp++;
        n_out++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got word=%h required no output", cur);
        end else begin
          expw = exp_q.pop_front();
          if (cur !== expw) begin
            n_err++;
            $display("FAIL out_word %0d: got {sop,eop,data}=%h required %h", n_out, cur, expw);
          end
        end
      end
      pv    = aso.valid;
      pr    = aso.ready;
      pword = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0;
    asi.valid = 1'b0;
    asi.sop   = 1'b0;
    asi.eop   = 1'b0;
    asi.data  = '0;
    aso.ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_asi_ready", 32'(asi.ready), 0);
    check("rst_aso_valid", 32'(aso.valid), 0);
    check("rst_aso_sop_eop", 32'({aso.sop, aso.eop}), 0);
    check("rst_aso_data", 32'(aso.data), 0);
    check("rst_err_frame", 32'(err_frame), 0);
    check("rst_sym_count", 32'(sym_count), 0);
    reset = 1'b0;
    @(negedge clk);
    check("hunt_asi_ready", 32'(asi.ready), 1);

    // T1: single ramp symbol, latency to first output
    push_exp(0, 0);
    send_sym(0, 0);
    @(negedge clk);
    check("lat_t1_valid", 32'(aso.valid), 0);
    @(negedge clk);
    check("lat_t2_valid", 32'(aso.valid), 1);
    check("lat_t2_sop", 32'(aso.sop), 1);
    drain();
    check("t1_sym_count", 32'(sym_count), 1);

    // T2: four symbols against a stalled source
    aso.ready = 1'b0;
    acc = 0;
    for (int s = 0; s < 4; s++) push_exp(100 + s * 64, 5000 + s * 64);
    fork
      for (int s = 0; s < 4; s++) send_sym(100 + s * 64, 5000 + s * 64);
      begin
        repeat (200) @(negedge clk);
        check("t2_accepted", 32'(acc), 128);
        check("t2_asi_ready_low", 32'(asi.ready), 0);
        check("t2_sym_count_stalled", 32'(sym_count), 1);
        bubbles = 0;
        contig = 1'b1;
        aso.ready = 1'b1;
      end
    join
    drain();
    contig = 1'b0;
    check("t2_bubbles", 32'(bubbles), 0);
    check("t2_sym_count", 32'(sym_count), 5);

    // T3: random backpressure, same data as T1
    push_exp(0, 0);
    push_exp(0, 0);
    rnd_mode = 1'b1;
    send_sym(0, 0);
    send_sym(0, 0);
    drain();
    rnd_mode = 1'b0;
    @(negedge clk);
    aso.ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t3_sym_count", 32'(sym_count), 7);

    // T4: sop injected at sample 30
    err_pulses = 0;
    push_exp(3000, 9000);
    for (int k = 0; k < 30; k++) put(samp(2000 + k, 7000 + k), (k == 0));
    put(samp(3000, 9000), 1'b1);
    check("t4_err_pulse", 32'(err_frame), 1);
    put(samp(3001, 9001), 1'b0);
    check("t4_err_clear", 32'(err_frame), 0);
    for (int k = 2; k < NFFT; k++) put(samp(3000 + k, 9000 + k), 1'b0);
    drain();
    check("t4_err_count", 32'(err_pulses), 1);
    check("t4_sym_count", 32'(sym_count), 8);

    // T5: stray samples in hunt are dropped
    for (int k = 0; k < 10; k++) begin
      check("t5_hunt_ready", 32'(asi.ready), 1);
      put(samp(777 + k, 777), 1'b0);
    end
    push_exp(400, 1400);
    send_sym(400, 1400);
    drain();
    check("t5_sym_count", 32'(sym_count), 9);

    // T6: reset in the middle of the body
    n0 = n_out;
    push_exp(600, 1600);
    send_sym(600, 1600);
    n = 0;
    while (n_out < n0 + CP + 20 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_body20", 32'(n_out - n0), CP + 20);
    check("t6_pre_reset_valid", 32'(aso.valid), 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid_drop", 32'(aso.valid), 0);
    check("t6_rst_sym_count", 32'(sym_count), 0);
    check("t6_rst_asi_ready", 32'(asi.ready), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_post_asi_ready", 32'(asi.ready), 1);
    check("t6_post_valid", 32'(aso.valid), 0);
    push_exp(800, 1800);
    send_sym(800, 1800);
    drain();
    check("t6_sym_count", 32'(sym_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
